// File: rtl/add_compare_select_if.sv
// Bundle between the branch-metric unit (master) and the add-compare-select stage (slave).
// Ports:
//   en_acs, i_start, i_valid, i_dist   master -> slave: enable, restart, step valid, branch metrics
//   o_valid, o_surv, o_pm, o_norm      slave -> master: step result, survivors, path metrics, norm flag
//   o_best_state, o_best_pm            slave -> master: min-metric state and value (optional feature)
interface add_compare_select_if #(
    parameter int unsigned STATE_NUM = 4,
    parameter int unsigned BM_W      = 3,
    parameter int unsigned PM_W      = 8
);
    localparam int unsigned SW = (STATE_NUM > 1) ? $clog2(STATE_NUM) : 1;

    logic                                en_acs;
    logic                                i_start;
    logic                                i_valid;
    // Branch metric indexed [prev state][input bit].
    logic [STATE_NUM-1:0][1:0][BM_W-1:0] i_dist;

    logic                                o_valid;
    logic [STATE_NUM-1:0]                o_surv;
    logic [STATE_NUM-1:0][PM_W-1:0]      o_pm;
    logic                                o_norm;
    logic [SW-1:0]                       o_best_state;
    logic [PM_W-1:0]                     o_best_pm;

    modport master (
        output en_acs, i_start, i_valid, i_dist,
        input  o_valid, o_surv, o_pm, o_norm, o_best_state, o_best_pm
    );

    modport slave (
        input  en_acs, i_start, i_valid, i_dist,
        output o_valid, o_surv, o_pm, o_norm, o_best_state, o_best_pm
    );
endinterface

// File: rtl/add_compare_select.sv
// Radix-2 add-compare-select stage of the Viterbi decoder.
// Each accepted trellis step updates every path metric and emits one survivor bit per state.
// Metrics are normalized by clearing all MSBs once every new metric has its MSB set.
// Optional feature macro: ACS_BEST_STATE_EN (registered argmin of the new metrics).
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   add_compare_select_if.slave (handshake, branch metrics in; survivors, metrics out)
module add_compare_select #(
    parameter int unsigned STATE_NUM = 4,
    parameter int unsigned BM_W      = 3,
    parameter int unsigned PM_W      = 8
) (
    input logic                clk,
    input logic                rst,
    add_compare_select_if.slave bus
);
    localparam int unsigned SW = (STATE_NUM > 1) ? $clog2(STATE_NUM) : 1;
    localparam logic [PM_W-1:0] PM_QUARTER = PM_W'(1) << (PM_W - 2);

    logic [STATE_NUM-1:0][PM_W-1:0] pm_q, init_pm, cand_pm, new_pm;
    logic [STATE_NUM-1:0]           surv_q, new_surv, msb_vec;
    logic                           valid_q, norm_q, norm_d;

    // One ACS butterfly half per next state; predecessor indices are elaboration constants.
    for (genvar ns = 0; ns < STATE_NUM; ns++) begin : g_acs
        localparam int unsigned P0 = (2 * ns) % STATE_NUM;
        localparam int unsigned P1 = P0 + 1;
        localparam int unsigned B  = ns / (STATE_NUM / 2);

        logic [PM_W:0]   c0_raw, c1_raw;
        logic [PM_W-1:0] c0, c1;

        assign c0_raw = {1'b0, pm_q[P0]} + {{(PM_W + 1 - BM_W){1'b0}}, bus.i_dist[P0][B]};
        assign c1_raw = {1'b0, pm_q[P1]} + {{(PM_W + 1 - BM_W){1'b0}}, bus.i_dist[P1][B]};
        assign c0     = c0_raw[PM_W] ? {PM_W{1'b1}} : c0_raw[PM_W-1:0];
        assign c1     = c1_raw[PM_W] ? {PM_W{1'b1}} : c1_raw[PM_W-1:0];

        // Strict compare: a tie keeps the even predecessor.
        assign new_surv[ns] = (c1 < c0);
        assign cand_pm[ns]  = new_surv[ns] ? c1 : c0;
        assign msb_vec[ns]  = cand_pm[ns][PM_W-1];
        assign init_pm[ns]  = (ns == 0) ? '0 : PM_QUARTER;
    end

    assign norm_d = &msb_vec;

    always_comb begin
        new_pm = cand_pm;
        if (norm_d) begin
            for (int unsigned s = 0; s < STATE_NUM; s++) begin
                new_pm[s][PM_W-1] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pm_q    <= init_pm;
            surv_q  <= '0;
            valid_q <= 1'b0;
            norm_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            norm_q  <= 1'b0;
            if (bus.en_acs) begin
                if (bus.i_start) begin
                    pm_q   <= init_pm;
                    surv_q <= '0;
                end else if (bus.i_valid) begin
                    pm_q    <= new_pm;
                    surv_q  <= new_surv;
                    valid_q <= 1'b1;
                    norm_q  <= norm_d;
                end
            end
        end
    end

    assign bus.o_pm    = pm_q;
    assign bus.o_surv  = surv_q;
    assign bus.o_valid = valid_q;
    assign bus.o_norm  = norm_q;

`ifdef ACS_BEST_STATE_EN
    logic [SW-1:0]   best_state_d, best_state_q;
    logic [PM_W-1:0] best_pm_d, best_pm_q;

    // Linear scan with strict less-than so ties resolve to the lowest index.
    always_comb begin
        best_state_d = '0;
        best_pm_d    = new_pm[0];
        for (int unsigned s = 1; s < STATE_NUM; s++) begin
            if (new_pm[s] < best_pm_d) begin
                best_pm_d    = new_pm[s];
                best_state_d = SW'(s);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_state_q <= '0;
            best_pm_q    <= '0;
        end else if (bus.en_acs) begin
            if (bus.i_start) begin
                best_state_q <= '0;
                best_pm_q    <= '0;
            end else if (bus.i_valid) begin
                best_state_q <= best_state_d;
                best_pm_q    <= best_pm_d;
            end
        end
    end

    assign bus.o_best_state = best_state_q;
    assign bus.o_best_pm    = best_pm_q;
`else
    assign bus.o_best_state = '0;
    assign bus.o_best_pm    = '0;
`endif
endmodule

// File: tb/tb_add_compare_select.sv
module tb_add_compare_select;
    localparam int N    = 4;
    localparam int BM_W = 3;
    localparam int PM_W = 8;
    localparam int PMAX = (1 << PM_W) - 1;
    localparam int HALF = 1 << (PM_W - 1);

    typedef struct {
        int pm[N];
        int surv;
        int norm;
        int bs;
        int bpm;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    add_compare_select_if #(.STATE_NUM(N), .BM_W(BM_W), .PM_W(PM_W)) bus ();

    add_compare_select #(.STATE_NUM(N), .BM_W(BM_W), .PM_W(PM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   mpm[N];
    int   msurv, mbs, mbpm;
    bit   exp_valid;
    int   dist_cur[N][2];
    int   total = 0;
    int   bad   = 0;
    int   norm_seen = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int exp_bs();
`ifdef ACS_BEST_STATE_EN
        return mbs;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_bpm();
`ifdef ACS_BEST_STATE_EN
        return mbpm;
`else
        return 0;
`endif
    endfunction

    task automatic model_init();
        for (int s = 0; s < N; s++) mpm[s] = (s == 0) ? 0 : (1 << (PM_W - 2));
        msurv     = 0;
        mbs       = 0;
        mbpm      = 0;
        exp_valid = 1'b0;
    endtask

    // Forward view of the trellis: every (state, bit) edge offers a candidate to its successor.
    task automatic model_step();
        int   best[N];
        int   sv[N];
        bit   all_hi;
        exp_t e;
        for (int s = 0; s < N; s++) best[s] = -1;
        for (int s = 0; s < N; s++) begin
            for (int b = 0; b < 2; b++) begin
                int ns, c;
                ns = b * (N / 2) + s / 2;
                c  = mpm[s] + dist_cur[s][b];
                if (c > PMAX) c = PMAX;
                if (best[ns] < 0 || c < best[ns]) begin
                    best[ns] = c;
                    sv[ns]   = s % 2;
                end
            end
        end
        all_hi = 1'b1;
        for (int s = 0; s < N; s++) if (best[s] < HALF) all_hi = 1'b0;
        msurv = 0;
        for (int s = 0; s < N; s++) begin
            mpm[s] = all_hi ? best[s] - HALF : best[s];
            msurv |= sv[s] << s;
        end
        mbs  = 0;
        mbpm = mpm[0];
        for (int s = 1; s < N; s++) begin
            if (mpm[s] < mbpm) begin
                mbpm = mpm[s];
                mbs  = s;
            end
        end
        e.pm   = mpm;
        e.surv = msurv;
        e.norm = all_hi ? 1 : 0;
        e.bs   = exp_bs();
        e.bpm  = exp_bpm();
        q.push_back(e);
    endtask

    task automatic drive(input bit en, input bit start, input bit valid);
        bus.en_acs  = en;
        bus.i_start = start;
        bus.i_valid = valid;
        for (int s = 0; s < N; s++)
            for (int b = 0; b < 2; b++)
                bus.i_dist[s][b] = BM_W'(dist_cur[s][b]);
    endtask

    task automatic cycle(input bit en, input bit start, input bit valid);
        drive(en, start, valid);
        @(posedge clk);
        #1;
        if (en && start) begin
            model_init();
        end else if (en && valid) begin
            model_step();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic set_dist_all(input int v);
        for (int s = 0; s < N; s++)
            for (int b = 0; b < 2; b++)
                dist_cur[s][b] = v;
    endtask

    task automatic set_dist_rand();
        for (int s = 0; s < N; s++)
            for (int b = 0; b < 2; b++)
                dist_cur[s][b] = $urandom_range(0, (1 << BM_W) - 1);
    endtask

    // Asynchronous reset asserted between edges while a step is presented; held for 3 edges.
    task automatic do_reset();
        rst = 1'b0;
        q.delete();
        model_init();
        #1;
        check("rst_async_valid", int'(bus.o_valid), 0);
        check("rst_async_pm0", int'(bus.o_pm[0]), 0);
        check("rst_async_pm1", int'(bus.o_pm[1]), 1 << (PM_W - 2));
        set_dist_rand();
        drive(1'b1, 1'b0, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    // Monitor: pops an expectation whenever the DUT presents a result.
    always @(negedge clk) begin
        if (bus.o_valid) begin
            check("o_valid", 1, int'(exp_valid));
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                for (int s = 0; s < N; s++) check($sformatf("o_pm[%0d]", s), int'(bus.o_pm[s]), e.pm[s]);
                check("o_surv", int'(bus.o_surv), e.surv);
                check("o_norm", int'(bus.o_norm), e.norm);
                check("o_best_state", int'(bus.o_best_state), e.bs);
                check("o_best_pm", int'(bus.o_best_pm), e.bpm);
                if (bus.o_norm) norm_seen++;
            end
        end else begin
            check("o_valid", 0, int'(exp_valid));
            for (int s = 0; s < N; s++) check($sformatf("hold_pm[%0d]", s), int'(bus.o_pm[s]), mpm[s]);
            check("hold_surv", int'(bus.o_surv), msurv);
            check("idle_norm", int'(bus.o_norm), 0);
            check("hold_best_state", int'(bus.o_best_state), exp_bs());
            check("hold_best_pm", int'(bus.o_best_pm), exp_bpm());
        end
    end

    initial begin
        rst = 1'b0;
        model_init();
        set_dist_all(0);
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;

        // Restart then a zero-distance step.
        set_dist_all(0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        // pm is now {0,64,0,64}: ns0 takes pm[0]+5 against pm[1]+0.
        set_dist_rand();
        dist_cur[0][0] = 5;
        dist_cur[1][0] = 0;
        cycle(1'b1, 1'b0, 1'b1);

        // Drive pm[0] == pm[1], then tie their candidates into ns0.
        set_dist_all(0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        set_dist_rand();
        dist_cur[0][0] = 3;
        dist_cur[1][0] = 3;
        cycle(1'b1, 1'b0, 1'b1);

        // Best-state example: {3,1,1,7}, tie resolves to state 1.
        set_dist_all(0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        set_dist_all(7);
        dist_cur[0][0] = 3;
        dist_cur[2][0] = 1;
        dist_cur[0][1] = 1;
        dist_cur[2][1] = 7;
        cycle(1'b1, 1'b0, 1'b1);

        // Constant worst-case distance until normalization kicks in.
        set_dist_all(0);
        cycle(1'b1, 1'b1, 1'b0);
        set_dist_all(7);
        norm_seen = 0;
        repeat (20) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        check("norm_seen", norm_seen, 1);

        // Stall with valid held high, then resume.
        set_dist_rand();
        cycle(1'b1, 1'b0, 1'b1);
        repeat (3) begin
            set_dist_rand();
            cycle(1'b0, 1'b0, 1'b1);
        end
        set_dist_rand();
        cycle(1'b1, 1'b0, 1'b1);

        // Restart beats a simultaneous step.
        set_dist_rand();
        cycle(1'b1, 1'b1, 1'b1);

        repeat (300) begin
            set_dist_rand();
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end

        // Reset while a result is on the outputs.
        set_dist_rand();
        cycle(1'b1, 1'b0, 1'b1);
        do_reset();

        repeat (200) begin
            set_dist_rand();
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
